// File: rtl/game_match_ctrl.sv
// rtl/game_match_ctrl.sv - best-of-ROUNDS match sequencer around the gamemachine guessing core
module game_match_ctrl #(
  parameter int ROUNDS      = 3,    // rounds per match, 1..15
  parameter int TIMEOUT_CYC = 1000, // idle cycles allowed per entry, >= 2
  parameter int CALC_LAT    = 2,    // core score latency after the last enter2, >= 1
  parameter int TOTAL_W     = 6     // match total width, >= 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               enter1_in,
  input  logic               enter2_in,
  output logic               core_rst_n,
  output logic               enter1_out,
  output logic               enter2_out,
  input  logic [3:0]         core_score1,
  input  logic [3:0]         core_score2,
  output logic [TOTAL_W-1:0] total1,
  output logic [TOTAL_W-1:0] total2,
  output logic [3:0]         round_idx,
  output logic [1:0]         phase,
  output logic               busy,
  output logic               match_done,
  output logic [1:0]         winner,
  output logic               forfeit
);

  typedef enum logic [2:0] {
    S_IDLE, S_RESTART, S_SETTLE, S_P1_ENT, S_P2_ENT, S_CALC_WAIT, S_ACCUM, S_DONE
  } state_e;

  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam int LAT_W = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(CALC_LAT - 1);
  localparam logic [3:0]       ROUNDS_4 = 4'(ROUNDS);
  localparam logic [3:0]       FORFEIT_PTS = 4'd8;

  state_e             state_q, state_d;
  logic [1:0]         ent_q, ent_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [TOTAL_W-1:0] total1_q, total1_d;
  logic [TOTAL_W-1:0] total2_q, total2_d;
  logic [3:0]         round_q, round_d;
  logic               e1_q, e2_q;
  logic               e1_rise, e2_rise;
  logic               round_last;
  state_e             round_end_state;

  // Adds a 4-bit score to a running total, clamping at all-ones.
  function automatic logic [TOTAL_W-1:0] sat_add(input logic [TOTAL_W-1:0] a,
                                                 input logic [3:0] b);
    logic [TOTAL_W:0] sum;
    sum = {1'b0, a} + (TOTAL_W+1)'(b);
    sat_add = sum[TOTAL_W] ? {TOTAL_W{1'b1}} : sum[TOTAL_W-1:0];
  endfunction

  // Button edges pass straight through so the core samples dataIn in the same cycle.
  assign e1_rise    = enter1_in & ~e1_q;
  assign e2_rise    = enter2_in & ~e2_q;
  assign enter1_out = e1_rise & (state_q == S_P1_ENT);
  assign enter2_out = e2_rise & (state_q == S_P2_ENT);
  assign core_rst_n = rst & (state_q != S_RESTART);

  assign round_last      = (round_q + 4'd1) == ROUNDS_4;
  assign round_end_state = round_last ? S_DONE : S_RESTART;

  assign total1    = total1_q;
  assign total2    = total2_q;
  assign round_idx = round_q;

  // Next-state, counters, score accumulation and timeout forfeit.
  always_comb begin
    state_d  = state_q;
    ent_d    = ent_q;
    tmo_d    = tmo_q;
    lat_d    = lat_q;
    total1_d = total1_q;
    total2_d = total2_q;
    round_d  = round_q;
    forfeit  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RESTART;
          total1_d = '0;
          total2_d = '0;
          round_d  = '0;
        end
      end
      S_RESTART: state_d = S_SETTLE;
      S_SETTLE: begin
        state_d = S_P1_ENT;
        ent_d   = '0;
        tmo_d   = '0;
      end
      S_P1_ENT: begin
        if (enter1_out) begin
          tmo_d = '0;
          if (ent_q == 2'd3) begin
            state_d = S_P2_ENT;
            ent_d   = '0;
          end else begin
            ent_d = ent_q + 2'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Player 1 stalled: player 2 collects the forfeit points.
          forfeit  = 1'b1;
          total2_d = sat_add(total2_q, FORFEIT_PTS);
          round_d  = round_q + 4'd1;
          state_d  = round_end_state;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_P2_ENT: begin
        if (enter2_out) begin
          tmo_d = '0;
          if (ent_q == 2'd3) begin
            state_d = S_CALC_WAIT;
            ent_d   = '0;
            lat_d   = '0;
          end else begin
            ent_d = ent_q + 2'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Player 2 stalled: player 1 collects the forfeit points.
          forfeit  = 1'b1;
          total1_d = sat_add(total1_q, FORFEIT_PTS);
          round_d  = round_q + 4'd1;
          state_d  = round_end_state;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_CALC_WAIT: begin
        if (lat_q == LAT_LAST) state_d = S_ACCUM;
        else                   lat_d   = lat_q + LAT_W'(1);
      end
      S_ACCUM: begin
        total1_d = sat_add(total1_q, core_score1);
        total2_d = sat_add(total2_q, core_score2);
        round_d  = round_q + 4'd1;
        state_d  = round_end_state;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state and totals.
  always_comb begin
    busy       = 1'b1;
    match_done = 1'b0;
    phase      = 2'd0;
    winner     = 2'b00;
    case (state_q)
      S_IDLE:      busy = 1'b0;
      S_P1_ENT:    phase = 2'd1;
      S_P2_ENT:    phase = 2'd2;
      S_CALC_WAIT: phase = 2'd3;
      S_ACCUM:     phase = 2'd3;
      S_DONE: begin
        busy       = 1'b0;
        match_done = 1'b1;
        if (total1_q > total2_q)      winner = 2'b01;
        else if (total2_q > total1_q) winner = 2'b10;
        else                          winner = 2'b11;
      end
      default: ;
    endcase
  end

  // State and datapath registers; button levels are captured every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ent_q    <= '0;
      tmo_q    <= '0;
      lat_q    <= '0;
      total1_q <= '0;
      total2_q <= '0;
      round_q  <= '0;
      e1_q     <= 1'b0;
      e2_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ent_q    <= ent_d;
      tmo_q    <= tmo_d;
      lat_q    <= lat_d;
      total1_q <= total1_d;
      total2_q <= total2_d;
      round_q  <= round_d;
      e1_q     <= enter1_in;
      e2_q     <= enter2_in;
    end
  end

endmodule
